// File: rtl/data_sram_responder.sv
// data_sram_responder: memory-side responder for the CPU data-SRAM
// request interface (sram-like handshake). A word-addressed array with
// byte-strobe writes sits behind a small in-order response queue whose
// entries count down a fixed latency before they are returned.
//
// Optional build macro: DSRAM_RAND_STALL_EN adds an 8-bit LFSR that
// randomly withholds addr_ok and randomly delays the head retire.
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW    = $clog2(QDEPTH);
  localparam int DEPTH = 1 << ADDR_W;

  // Word array; contents survive reset.
  logic [31:0] mem [DEPTH];

  // Queue storage: response data and remaining countdown per slot.
  logic [31:0] q_data [QDEPTH];
  logic [3:0]  q_rem  [QDEPTH];
  logic        slot_valid [QDEPTH];
  logic [PW-1:0] slot_off [QDEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [1:0]    rst_sync;

  logic [ADDR_W-1:0] idx;
  logic              space;
  logic              accept;
  logic              head_due;
  logic              pop;
  logic              issue_en;
  logic              retire_en;

  // size is informational; address bits outside the word index alias.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  assign idx = addr[ADDR_W+1:2];

`ifdef DSRAM_RAND_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR (taps 8,6,5,4) providing pseudo-random stall decisions.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign issue_en  = lfsr[0];
  assign retire_en = lfsr[1];
`else
  assign issue_en  = 1'b1;
  assign retire_en = 1'b1;
`endif

  // A slot is occupied when its distance from head is below count; the
  // accept decision sees count before any same-cycle pop.
  assign space    = count < (PW+1)'(QDEPTH);
  assign addr_ok  = rst_sync[1] & space & issue_en;
  assign accept   = req & addr_ok;
  assign head_due = (count != '0) && (q_rem[head] == 4'd0);
  assign pop      = head_due & retire_en;

  // Decode which queue slots currently hold an outstanding request.
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      slot_off[i]   = PW'(i) - head;
      slot_valid[i] = {1'b0, slot_off[i]} < count;
    end
  end

  // Queue control: reset release, pointers, occupancy and the response port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync <= 2'b00;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      data_ok  <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      if (accept) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head  <= head + 1'b1;
        rdata <= q_data[head];
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      data_ok <= pop;
    end
  end

  // Queue payload: count down live entries and load a new one on accept.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (slot_valid[i] && (q_rem[i] != 4'd0)) begin
        q_rem[i] <= q_rem[i] - 4'd1;
      end
    end
    if (accept) begin
      q_rem[tail]  <= 4'(LATENCY);
      q_data[tail] <= wr ? 32'd0 : mem[idx];
    end
  end

  // Byte-strobed array write at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
